// File: rtl/gftt_pkg.sv
// Shared encodings and constants for the GFTT gradient stage.
// Mode/border encodings, kernel weights and the window FSM state type.
package gftt_pkg;

    localparam logic GFTT_SOBEL  = 1'b0;
    localparam logic GFTT_SCHARR = 1'b1;

    localparam int unsigned SOBEL_W0  = 1;
    localparam int unsigned SOBEL_W1  = 2;
    localparam int unsigned SCHARR_W0 = 3;
    localparam int unsigned SCHARR_W1 = 10;

    localparam int unsigned BRD_ZERO = 0;
    localparam int unsigned BRD_REPL = 1;

    typedef enum logic [1:0] {
        StIdle,
        StLine,
        StFlush
    } win_state_e;

endpackage

// File: rtl/gftt_grad_win.sv
// Line FSM, 3x3 pixel window, border replication, per-line mode latch and
// sticky protocol-error flag. Emits one window per accepted column.
module gftt_grad_win #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned BORDER = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PIX_W-1:0]            i_line0,
    input  logic [PIX_W-1:0]            i_line1,
    input  logic [PIX_W-1:0]            i_line2,
    input  logic                        i_vin,
    input  logic                        i_first,
    input  logic                        i_last,
    input  logic                        i_mode,
    input  logic                        i_err_clr,
    output logic [2:0][2:0][PIX_W-1:0]  o_win,
    output logic                        o_emit,
    output logic                        o_zero,
    output logic                        o_mode,
    output logic                        o_err
);
    import gftt_pkg::*;

    win_state_e       r_state, w_state_d;
    logic [PIX_W-1:0] w_pix [3];
    logic [PIX_W-1:0] r_wl  [3];
    logic [PIX_W-1:0] r_wc  [3];
    logic             r_two;
    logic             r_mode;
    logic             r_err;
    logic             w_load, w_shift, w_emit, w_flush, w_err_set;

    assign w_pix[0] = i_line0;
    assign w_pix[1] = i_line1;
    assign w_pix[2] = i_line2;

    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        w_shift   = 1'b0;
        w_emit    = 1'b0;
        w_flush   = 1'b0;
        w_err_set = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_vin) begin
                    if (i_first) begin
                        w_load    = 1'b1;
                        w_state_d = i_last ? StFlush : StLine;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            StLine: begin
                if (i_vin) begin
                    if (i_first) begin
                        // Restart: the old line is dropped without a flush
                        w_err_set = 1'b1;
                        w_load    = 1'b1;
                        w_state_d = i_last ? StFlush : StLine;
                    end else begin
                        w_shift = 1'b1;
                        w_emit  = 1'b1;
                        if (i_last) begin
                            w_state_d = StFlush;
                        end
                    end
                end
            end
            StFlush: begin
                w_emit    = 1'b1;
                w_flush   = 1'b1;
                w_err_set = i_vin;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_two   <= 1'b0;
            r_mode  <= 1'b0;
            r_err   <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                r_wl[r] <= '0;
                r_wc[r] <= '0;
            end
        end else begin
            r_state <= w_state_d;
            r_err   <= w_err_set | (r_err & ~i_err_clr);
            if (w_load) begin
                r_mode <= i_mode;
                r_two  <= 1'b0;
                for (int r = 0; r < 3; r++) begin
                    r_wc[r] <= w_pix[r];
                end
            end else if (w_shift) begin
                r_two <= 1'b1;
                for (int r = 0; r < 3; r++) begin
                    r_wl[r] <= r_wc[r];
                    r_wc[r] <= w_pix[r];
                end
            end
        end
    end

    // Column 0: left neighbour missing; flush: right neighbour missing
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            o_win[r][0] = r_two   ? r_wl[r] : r_wc[r];
            o_win[r][1] = r_wc[r];
            o_win[r][2] = w_flush ? r_wc[r] : w_pix[r];
        end
    end

    assign o_emit = w_emit;
    assign o_zero = (BORDER == BRD_ZERO) && (!r_two || w_flush);
    assign o_mode = r_mode;
    assign o_err  = r_err;

endmodule

// File: rtl/gftt_grad.sv
// 3x3 Sobel/Scharr gradient stage: window from gftt_grad_win feeding a
// 3-stage arithmetic pipeline (differences, weighting, sum + saturate).
module gftt_grad #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned OUT_W  = PIX_W + 5,
    parameter int unsigned BORDER = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PIX_W-1:0]        line0,
    input  logic [PIX_W-1:0]        line1,
    input  logic [PIX_W-1:0]        line2,
    input  logic                    vin,
    input  logic                    first_smpl,
    input  logic                    last_smpl,
    input  logic                    mode,
    input  logic                    err_clr,
    output logic signed [OUT_W-1:0] xgrd,
    output logic signed [OUT_W-1:0] ygrd,
    output logic                    vout,
    output logic                    err
);
    import gftt_pkg::*;

    localparam int unsigned DW = PIX_W + 1;
    localparam int unsigned SW = PIX_W + 6;
    localparam int unsigned EW = ((OUT_W > SW) ? OUT_W : SW) + 1;

    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

    logic [2:0][2:0][PIX_W-1:0] w_win;
    logic                       w_emit, w_zero, w_mode;
    logic                       w_unused_ctr;

    gftt_grad_win #(
        .PIX_W  (PIX_W),
        .BORDER (BORDER)
    ) u_win (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_line0   (line0),
        .i_line1   (line1),
        .i_line2   (line2),
        .i_vin     (vin),
        .i_first   (first_smpl),
        .i_last    (last_smpl),
        .i_mode    (mode),
        .i_err_clr (err_clr),
        .o_win     (w_win),
        .o_emit    (w_emit),
        .o_zero    (w_zero),
        .o_mode    (w_mode),
        .o_err     (err)
    );

    // Centre pixel carries zero weight in both kernels
    assign w_unused_ctr = ^w_win[1][1];

    // Stage 1: horizontal differences per row, vertical per column
    logic signed [DW-1:0] w_dx [3];
    logic signed [DW-1:0] w_dy [3];
    logic signed [DW-1:0] r_dx [3];
    logic signed [DW-1:0] r_dy [3];
    logic                 r_s1_vld, r_s1_zero, r_s1_mode;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_dx[i] = {1'b0, w_win[i][2]} - {1'b0, w_win[i][0]};
            w_dy[i] = {1'b0, w_win[2][i]} - {1'b0, w_win[0][i]};
        end
    end

    // Stage 2: weighting and partial sums
    logic signed [SW-1:0] w_w0, w_w1;
    logic signed [SW-1:0] w_ixo, w_ixm, w_iyo, w_iym;
    logic signed [SW-1:0] r_ixo, r_ixm, r_iyo, r_iym;
    logic                 r_s2_vld, r_s2_zero;

    always_comb begin
        w_w0  = (r_s1_mode == GFTT_SCHARR) ? SW'(SCHARR_W0) : SW'(SOBEL_W0);
        w_w1  = (r_s1_mode == GFTT_SCHARR) ? SW'(SCHARR_W1) : SW'(SOBEL_W1);
        w_ixo = w_w0 * (SW'(r_dx[0]) + SW'(r_dx[2]));
        w_ixm = w_w1 * SW'(r_dx[1]);
        w_iyo = w_w0 * (SW'(r_dy[0]) + SW'(r_dy[2]));
        w_iym = w_w1 * SW'(r_dy[1]);
    end

    // Stage 3: final sum and saturation
    logic signed [EW-1:0] w_xs, w_ys;

    assign w_xs = EW'(r_ixo) + EW'(r_ixm);
    assign w_ys = EW'(r_iyo) + EW'(r_iym);

    function automatic logic signed [OUT_W-1:0] sat_f(input logic signed [EW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[OUT_W-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[OUT_W-1:0];
        end
        return v[OUT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_dx[i] <= '0;
                r_dy[i] <= '0;
            end
            r_s1_vld  <= 1'b0;
            r_s1_zero <= 1'b0;
            r_s1_mode <= 1'b0;
            r_ixo     <= '0;
            r_ixm     <= '0;
            r_iyo     <= '0;
            r_iym     <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_zero <= 1'b0;
            xgrd      <= '0;
            ygrd      <= '0;
            vout      <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_dx[i] <= w_dx[i];
                r_dy[i] <= w_dy[i];
            end
            r_s1_vld  <= w_emit;
            r_s1_zero <= w_zero;
            r_s1_mode <= w_mode;
            r_ixo     <= w_ixo;
            r_ixm     <= w_ixm;
            r_iyo     <= w_iyo;
            r_iym     <= w_iym;
            r_s2_vld  <= r_s1_vld;
            r_s2_zero <= r_s1_zero;
            vout      <= r_s2_vld;
            if (r_s2_vld) begin
                xgrd <= r_s2_zero ? '0 : sat_f(w_xs);
                ygrd <= r_s2_zero ? '0 : sat_f(w_ys);
            end
        end
    end

endmodule

// File: tb/tb_gftt_grad.sv
// Self-checking bench: three gftt_grad configurations share one stimulus
// stream and are compared every cycle against a column-array reference model.
module tb_gftt_grad;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] line0 = '0, line1 = '0, line2 = '0;
    logic       vin = 1'b0, first_smpl = 1'b0, last_smpl = 1'b0, mode = 1'b0, err_clr = 1'b0;

    logic signed [12:0] x0, y0, x1, y1;
    logic signed [10:0] x2, y2;
    logic               v0, v1, v2, e0, e1, e2;

    always #5 clk = ~clk;

    // d0: replicate border, d1: zero border, d2: replicate border, narrow output
    gftt_grad #(.PIX_W(8), .OUT_W(13), .BORDER(1)) u_d0 (
        .clk(clk), .rst_n(rst_n), .line0(line0), .line1(line1), .line2(line2),
        .vin(vin), .first_smpl(first_smpl), .last_smpl(last_smpl), .mode(mode),
        .err_clr(err_clr), .xgrd(x0), .ygrd(y0), .vout(v0), .err(e0)
    );
    gftt_grad #(.PIX_W(8), .OUT_W(13), .BORDER(0)) u_d1 (
        .clk(clk), .rst_n(rst_n), .line0(line0), .line1(line1), .line2(line2),
        .vin(vin), .first_smpl(first_smpl), .last_smpl(last_smpl), .mode(mode),
        .err_clr(err_clr), .xgrd(x1), .ygrd(y1), .vout(v1), .err(e1)
    );
    gftt_grad #(.PIX_W(8), .OUT_W(11), .BORDER(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .line0(line0), .line1(line1), .line2(line2),
        .vin(vin), .first_smpl(first_smpl), .last_smpl(last_smpl), .mode(mode),
        .err_clr(err_clr), .xgrd(x2), .ygrd(y2), .vout(v2), .err(e2)
    );

    typedef struct {
        int cyc;
        int x;
        int y;
    } exp_t;

    exp_t q [3][$];
    int   last_x [3];
    int   last_y [3];
    int   lc [3][$];
    int   mst;
    bit   lmode;
    bit   merr;
    int   n_chk = 0;
    int   n_pass = 0;
    int   tcyc = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, tcyc);
    endtask

    function automatic int sat(input int v, input int w);
        int mx = (1 << (w - 1)) - 1;
        if (v > mx) return mx;
        if (v < -mx - 1) return -mx - 1;
        return v;
    endfunction

    function automatic int pix_at(input int r, input int c);
        int n = lc[r].size();
        if (c < 0) c = 0;
        if (c > n - 1) c = n - 1;
        return lc[r][c];
    endfunction

    // Expected results for centre column k, emitted at posedge p
    function automatic void emit(input int k, input int p);
        int   n = lc[0].size();
        int   w0 = lmode ? 3 : 1;
        int   w1 = lmode ? 10 : 2;
        int   ix, iy;
        bit   edge_col;
        exp_t e;
        ix = w0 * (pix_at(0, k + 1) - pix_at(0, k - 1))
           + w1 * (pix_at(1, k + 1) - pix_at(1, k - 1))
           + w0 * (pix_at(2, k + 1) - pix_at(2, k - 1));
        iy = w0 * (pix_at(2, k - 1) - pix_at(0, k - 1))
           + w1 * (pix_at(2, k) - pix_at(0, k))
           + w0 * (pix_at(2, k + 1) - pix_at(0, k + 1));
        edge_col = (k == 0) || (k == n - 1);
        e.cyc = p + 3;
        e.x = sat(ix, 13);
        e.y = sat(iy, 13);
        q[0].push_back(e);
        e.x = edge_col ? 0 : sat(ix, 13);
        e.y = edge_col ? 0 : sat(iy, 13);
        q[1].push_back(e);
        e.x = sat(ix, 11);
        e.y = sat(iy, 11);
        q[2].push_back(e);
    endfunction

    function automatic void start_line(input bit l, input bit m, input int p0, input int p1,
                                       input int p2);
        for (int r = 0; r < 3; r++) lc[r].delete();
        lc[0].push_back(p0);
        lc[1].push_back(p1);
        lc[2].push_back(p2);
        lmode = m;
        mst = l ? 2 : 1;
    endfunction

    // mst: 0 idle, 1 inside a line, 2 flush cycle after the last column
    function automatic void model_step(input bit v, input bit f, input bit l, input bit m,
                                       input int p0, input int p1, input int p2, input bit clr);
        bit e = 1'b0;
        case (mst)
            0: if (v) begin
                if (f) start_line(l, m, p0, p1, p2);
                else e = 1'b1;
            end
            1: if (v) begin
                if (f) begin
                    e = 1'b1;
                    start_line(l, m, p0, p1, p2);
                end else begin
                    lc[0].push_back(p0);
                    lc[1].push_back(p1);
                    lc[2].push_back(p2);
                    emit(lc[0].size() - 2, tcyc);
                    if (l) mst = 2;
                end
            end
            default: begin
                emit(lc[0].size() - 1, tcyc);
                if (v) e = 1'b1;
                mst = 0;
            end
        endcase
        merr = e ? 1'b1 : (clr ? 1'b0 : merr);
    endfunction

    function automatic void model_reset();
        mst = 0;
        merr = 1'b0;
        lmode = 1'b0;
        for (int d = 0; d < 3; d++) begin
            q[d].delete();
            last_x[d] = 0;
            last_y[d] = 0;
            lc[d].delete();
        end
    endfunction

    task automatic chk_dut(input int d, input bit vo, input int xo, input int yo, input bit eo);
        exp_t e;
        if (q[d].size() > 0 && q[d][0].cyc == tcyc) begin
            e = q[d].pop_front();
            check_eq($sformatf("d%0d vout", d), int'(vo), 1);
            check_eq($sformatf("d%0d xgrd", d), xo, e.x);
            check_eq($sformatf("d%0d ygrd", d), yo, e.y);
            last_x[d] = e.x;
            last_y[d] = e.y;
        end else begin
            check_eq($sformatf("d%0d vout idle", d), int'(vo), 0);
            check_eq($sformatf("d%0d xgrd hold", d), xo, last_x[d]);
            check_eq($sformatf("d%0d ygrd hold", d), yo, last_y[d]);
        end
        check_eq($sformatf("d%0d err", d), int'(eo), int'(merr));
    endtask

    task automatic drive(input bit v, input bit f, input bit l, input bit m, input int p0,
                         input int p1, input int p2, input bit clr);
        @(negedge clk);
        tcyc++;
        chk_dut(0, v0, x0, y0, e0);
        chk_dut(1, v1, x1, y1, e1);
        chk_dut(2, v2, x2, y2, e2);
        vin        = v;
        first_smpl = f;
        last_smpl  = l;
        mode       = m;
        line0      = 8'(p0);
        line1      = 8'(p1);
        line2      = 8'(p2);
        err_clr    = clr;
        if (rst_n) model_step(v, f, l, m, p0 & 255, p1 & 255, p2 & 255, clr);
    endtask

    task automatic idle(input bit clr);
        drive(1'b0, 1'b0, 1'b0, 1'(($urandom)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), clr);
    endtask

    // 0 ramp, 1 step down-brighter, 2 step up-brighter, 3 random, 4 flat
    function automatic int pix(input int kind, input int r, input int c);
        case (kind)
            0: return c * 10;
            1: return (r == 0) ? 0 : ((r == 2) ? 255 : 128);
            2: return (r == 0) ? 255 : ((r == 2) ? 0 : 128);
            3: return int'($urandom_range(0, 255));
            default: return 77;
        endcase
    endfunction

    task automatic send_line(input int n, input bit m, input int kind, input int gap);
        for (int c = 0; c < n; c++) begin
            if (gap == 1 && c > 0) begin
                idle(1'b0);
                idle(1'b0);
            end else if (gap == 2) begin
                while ($urandom_range(0, 2) == 0) idle(1'b0);
            end
            drive(1'b1, c == 0, c == n - 1, m, pix(kind, 0, c), pix(kind, 1, c),
                  pix(kind, 2, c), 1'b0);
        end
        idle(1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        idle(1'b0);
        idle(1'b0);
        rst_n = 1'b1;
    endtask

    task automatic rand_line();
        int n = int'($urandom_range(1, 12));
        bit m = 1'($urandom);
        int kind = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 3;
        for (int c = 0; c < n; c++) begin
            while ($urandom_range(0, 2) == 0) idle($urandom_range(0, 9) == 0);
            drive(1'b1, (c == 0) || ($urandom_range(0, 24) == 0), c == n - 1,
                  (c == 0) ? m : 1'($urandom), pix(kind, 0, c), pix(kind, 1, c),
                  pix(kind, 2, c), $urandom_range(0, 9) == 0);
        end
        if ($urandom_range(0, 5) == 0)
            drive(1'b1, 1'($urandom), 1'b0, 1'b0, 9, 9, 9, 1'b0);
        else
            idle(1'b0);
        repeat ($urandom_range(0, 2)) idle($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 7) == 0) begin
            drive(1'b1, 1'b0, 1'($urandom), 1'b0, 5, 5, 5, 1'b0);
            idle(1'b0);
        end
    endtask

    initial begin
        model_reset();
        idle(1'b0);
        idle(1'b0);
        rst_n = 1'b1;

        send_line(8, 1'b0, 0, 0);
        repeat (3) idle(1'b0);
        send_line(4, 1'b0, 1, 0);
        send_line(4, 1'b1, 1, 0);
        send_line(4, 1'b1, 2, 0);
        idle(1'b0);
        send_line(8, 1'b0, 0, 1);
        repeat (4) idle(1'b0);

        // First sample right after last_smpl lands in the flush cycle
        for (int c = 0; c < 3; c++) drive(1'b1, c == 0, c == 2, 1'b0, c * 10, c * 10, c * 10, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 50, 50, 50, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 77, 77, 77, 1'b0);
        idle(1'b0);
        repeat (4) idle(1'b0);

        // Stray sample in idle, then a new error racing err_clr
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1, 2, 3, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1, 2, 3, 1'b1);
        idle(1'b1);
        idle(1'b0);

        // first_smpl mid-line abandons the line
        drive(1'b1, 1'b1, 1'b0, 1'b0, 10, 20, 30, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 40, 50, 60, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 255, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 255, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // Reset mid-line with results still in flight
        for (int c = 0; c < 3; c++) drive(1'b1, c == 0, 1'b0, 1'b0, c * 10, c * 10, c * 10, 1'b0);
        do_reset();
        idle(1'b0);
        send_line(8, 1'b0, 0, 0);
        repeat (3) idle(1'b0);

        repeat (60) rand_line();
        repeat (8) idle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
